pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Receive-side counterpart of the on-chip PWM generator. Measures an incoming PWM
//  waveform in clk cycles: high time and period between rising edges.
//  Publishes each complete measurement with a 1-cycle valid strobe.
//  Sits on a ui_in pin for loopback/self-test of the PWM output, or for decoding external PWM.
// PARAMETERS
//  CNT_W     16  width of the cycle counters and of high_cnt/period_cnt
//  FILT_LEN   3  consecutive equal samples required by the glitch filter (macro only), >=2
// PORTS
//  clk         in   1      clock, all logic on posedge
//  rst_n       in   1      synchronous, active-low reset
//  ena         in   1      capture enable; 0 = hold outputs, FSM parked in IDLE
//  pwm_in      in   1      asynchronous PWM input
//  high_cnt    out  CNT_W  cycles pwm was high in last complete period
//  period_cnt  out  CNT_W  cycles between last two rising edges
//  meas_valid  out  1      1-cycle pulse, high_cnt/period_cnt updated this cycle
//  timeout     out  1      sticky; counter saturated with no edge (stuck 0%/100%)
//  pwm_level   out  1      synchronised (and filtered) level of pwm_in
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, all sync/filter flops 0, p=0, h=0.
//    Outputs: high_cnt=0, period_cnt=0, meas_valid=0, timeout=0, pwm_level=0.
//    Reset mid-period discards the partial measurement.
//  - Input path: 2-FF synchroniser s1->s2. lvl = s2 (or filter output).
//    lvl_d = lvl delayed 1 cycle. rise = lvl & ~lvl_d; fall = ~lvl & lvl_d.
//    pwm_level = lvl.
//  - Run counter p (CNT_W bits), stored high time h (CNT_W bits).
//  - FSM states and transitions:
//      IDLE: p held 0. On rise -> HIGH, p<=1.
//      HIGH: on fall -> LOW, h<=p, p<=p+1. Else p<=p+1.
//      LOW:  on rise -> HIGH: period_cnt<=p, high_cnt<=h, meas_valid<=1, timeout<=0, p<=1.
//            Else p<=p+1.
//  - Counting: p counts synced cycles, so a 10-cycle period with 3 high cycles gives
//    h=3, p=10 at the next rise.
//  - Saturation: in HIGH or LOW with p=2^CNT_W-1 and no edge this cycle:
//    timeout<=1, state<=IDLE, p<=0, no meas_valid, high_cnt/period_cnt hold.
//    Edge coincident with p=max: the edge wins and is processed normally.
//  - First measurement needs two rising edges. The first rise after reset/IDLE only
//    starts counting; a fall seen in IDLE is ignored.
//  - Latency (no filter): edge 0 = first posedge sampling pwm_in=1; meas_valid and new
//    outputs are visible after edge 2. Filter adds FILT_LEN-1 cycles.
//  - ena=0: next posedge state<=IDLE, p<=0, meas_valid<=0. Sync flops keep running;
//    outputs and timeout hold. Re-enable needs two rises before the next valid.
//  - meas_valid is never asserted two cycles in a row (minimum period is 2 cycles).
// CONFIGURATION
//  PWM_CAP_FILTER_EN defined: stability filter after s2.
//    - lvl changes only after FILT_LEN consecutive equal s2 samples.
//    - Pulses shorter than FILT_LEN cycles are rejected; both edges are delayed equally,
//      so h and p are unaffected.
//    - Filter counter width is $clog2(FILT_LEN+1); reset value 0, lvl reset 0.
//  PWM_CAP_FILTER_EN undefined: lvl = s2; FILT_LEN unused; no filter logic.
// TESTING
//  1 Reset, then 10-cycle PWM with 5 high -> 1st meas_valid after 2nd rise:
//    high_cnt=5, period_cnt=10; repeat every 10 cycles.
//  2 Duty sweep 1..9 of 10 -> high_cnt tracks 1..9, period_cnt=10 throughout.
//  3 CNT_W=4, hold pwm_in=1 -> after 15 cycles in HIGH timeout=1, state IDLE, outputs held.
//    Resume PWM -> timeout clears with next meas_valid.
//  4 ena=0 mid-period for 20 cycles, then 1 -> no meas_valid until two rises;
//    the first valid after re-enable is exact.
//  5 rst_n=0 for 1 cycle mid-HIGH -> all outputs 0 next cycle; next valid needs two rises.
//  6 Filter build, FILT_LEN=3: 2-cycle low glitch inside a high phase -> ignored,
//    high_cnt unchanged. Without the macro the same glitch yields a short period.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM waveform in clk cycles.
//   It reports the high time and the period between two rising edges.
// Latency: meas_valid is visible after the 2nd posedge following the posedge that
//   first samples the closing rising edge. The optional filter adds FILT_LEN-1 cycles.
// Backpressure: none. Each result is a single-cycle meas_valid strobe. The outputs
//   hold their values until the next complete measurement.
//
// Optional build macro: PWM_CAP_FILTER_EN. When it is defined, a stability filter
//   after the synchroniser rejects pulses shorter than FILT_LEN cycles.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst_n       synchronous active-low reset
//   ena         capture enable; 0 parks the FSM in IDLE and holds the outputs
//   pwm_in      asynchronous PWM input
//   high_cnt    high cycles of the last complete period
//   period_cnt  cycles between the last two rising edges
//   meas_valid  1-cycle strobe; high_cnt/period_cnt were updated this cycle
//   timeout     sticky; the run counter saturated without an edge
//   pwm_level   synchronised (and filtered) input level
module pwm_capture #(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             timeout,
    output logic             pwm_level
);

    // A filter that needs one sample or fewer cannot reject anything.
    if (FILT_LEN < 2) begin : g_bad_filt_len
        $error("pwm_capture: FILT_LEN must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Input path: 2-FF synchroniser, optional stability filter, edge detect
    // ------------------------------------------------------------------
    logic s1_q, s2_q;
    logic lvl;
    logic lvl_dly_q;
    logic rise, fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
        end
    end

`ifdef PWM_CAP_FILTER_EN
    localparam int FCW = $clog2(FILT_LEN + 1);
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILT_LEN - 1);

    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           flvl_q;

    // fcnt_q counts the earlier consecutive samples in which s2 has differed
    // from the filtered level. The level is changed combinationally when the
    // FILT_LEN-th differing sample is present. This rejects pulses shorter
    // than FILT_LEN cycles and adds only FILT_LEN-1 cycles of delay.
    assign lvl = ((s2_q != flvl_q) && (fcnt_q == FCNT_LAST)) ? s2_q : flvl_q;

    always_comb begin
        fcnt_d = '0;
        if (s2_q != lvl) begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt_q <= '0;
            flvl_q <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            flvl_q <= lvl;
        end
    end
`else
    assign lvl = s2_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_dly_q <= 1'b0;
        end else begin
            lvl_dly_q <= lvl;
        end
    end

    assign rise      = lvl & ~lvl_dly_q;
    assign fall      = ~lvl & lvl_dly_q;
    assign pwm_level = lvl;

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] p_q, p_d;          // run counter since the last rise
    logic [CNT_W-1:0] h_q, h_d;          // high time captured at the fall
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             tout_q, tout_d;

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        h_d      = h_q;
        high_d   = high_q;
        period_d = period_q;
        valid_d  = 1'b0;
        tout_d   = tout_q;

        if (!ena) begin
            // Park and drop any partial measurement; published results and
            // the sticky timeout stay visible.
            state_d = IDLE;
            p_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Only a rise starts a measurement. A fall here is ignored.
                    p_d = '0;
                    if (rise) begin
                        state_d = HIGH;
                        p_d     = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d = LOW;
                        h_d     = p_q;
                        p_d     = p_q + 1'b1;
                    end else if (p_q == CNT_MAX) begin
                        // Stuck high: give up and wait for a fresh rise.
                        state_d = IDLE;
                        p_d     = '0;
                        tout_d  = 1'b1;
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        // A rise at p == CNT_MAX still completes normally.
                        state_d  = HIGH;
                        period_d = p_q;
                        high_d   = h_q;
                        valid_d  = 1'b1;
                        tout_d   = 1'b0;
                        p_d      = CNT_ONE;
                    end else if (p_q == CNT_MAX) begin
                        // Stuck low.
                        state_d = IDLE;
                        p_d     = '0;
                        tout_d  = 1'b1;
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    p_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            p_q      <= '0;
            h_q      <= '0;
            high_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            h_q      <= h_d;
            high_q   <= high_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            tout_q   <= tout_d;
        end
    end

    assign high_cnt   = high_q;
    assign period_cnt = period_q;
    assign meas_valid = valid_q;
    assign timeout    = tout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed stimulus for pwm_capture with a scoreboard.
//   Each PWM period that will be closed by a later rise pushes its
//   (high, period) pair into a queue. A monitor pops and compares the pair
//   on every meas_valid. The DUT is built with CNT_W=4, so saturation
//   happens after 15 cycles.
module tb_pwm_capture;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             timeout;
    logic             pwm_level;

    pwm_capture #(.CNT_W(CNT_W), .FILT_LEN(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .pwm_level  (pwm_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One PWM period: hi cycles high, then per-hi cycles low, driven from negedge.
    // push=1 when a later rise will close this period and publish it.
    task automatic pulse(input int hi, input int per, input bit push);
        exp_t e;
        if (push) begin
            e.h = CNT_W'(hi);
            e.p = CNT_W'(per);
            exp_q.push_back(e);
        end
        pwm_in = 1'b1;
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        repeat (per - hi) @(negedge clk);
    endtask

    task automatic chk_outputs(input string tag, input int h, input int p,
                               input int v, input int t, input int l);
        chk({tag, "_high_cnt"},   int'(high_cnt),   h);
        chk({tag, "_period_cnt"}, int'(period_cnt), p);
        chk({tag, "_meas_valid"}, int'(meas_valid), v);
        chk({tag, "_timeout"},    int'(timeout),    t);
        chk({tag, "_pwm_level"},  int'(pwm_level),  l);
    endtask

    // Monitor: compares every published measurement against the scoreboard.
    initial begin : monitor
        logic prev_vld;
        exp_t e;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (meas_valid) begin
                chk("valid_gap", int'(prev_vld), 0);
                chk("valid_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("meas_high_cnt",   int'(high_cnt),   int'(e.h));
                    chk("meas_period_cnt", int'(period_cnt), int'(e.p));
                    chk("meas_timeout_clr", int'(timeout),   0);
                end
            end
            prev_vld = meas_valid;
        end
    end

    initial begin : stim
        rst_n  = 1'b0;
        ena    = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 10-cycle period, 5 high, repeated.
        repeat (3) pulse(5, 10, 1'b1);
        // Duty sweep 1..9 of 10.
        for (int h = 1; h <= 9; h++) pulse(h, 10, 1'b1);
        // Minimum period of 2 cycles, back to back.
        pulse(1, 2, 1'b1);
        pulse(1, 2, 1'b1);
        // Closing rise arrives exactly when p == max: the edge wins.
        pulse(7, 15, 1'b1);
        // This rise publishes 7/15. The input then stays low until saturation.
        pulse(5, 10, 1'b0);
        repeat (15) @(negedge clk);
        chk("stuck_low_timeout", int'(timeout),    1);
        chk("stuck_low_high",    int'(high_cnt),   7);
        chk("stuck_low_period",  int'(period_cnt), 15);

        // Stuck high from IDLE: saturates again with outputs held.
        pwm_in = 1'b1;
        repeat (25) @(negedge clk);
        chk("stuck_high_timeout", int'(timeout),    1);
        chk("stuck_high_high",    int'(high_cnt),   7);
        chk("stuck_high_period",  int'(period_cnt), 15);
        chk("stuck_high_level",   int'(pwm_level),  1);

        // Resume PWM. The next valid clears timeout, which the monitor checks.
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        pulse(3, 10, 1'b1);
        pulse(4, 12, 1'b1);
        pulse(2, 8, 1'b1);

        // Disable mid-period. Pulses while disabled must publish nothing.
        pwm_in = 1'b1;
        repeat (4) @(negedge clk);
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        ena = 1'b0;
        pulse(5, 10, 1'b0);
        pulse(5, 10, 1'b0);
        chk("ena_off_high",    int'(high_cnt),   2);
        chk("ena_off_period",  int'(period_cnt), 8);
        chk("ena_off_timeout", int'(timeout),    0);
        ena = 1'b1;
        repeat (3) @(negedge clk);
        pulse(6, 10, 1'b1);
        pulse(7, 11, 1'b1);
        pulse(3, 9, 1'b1);

        // Reset for one cycle in the middle of a high phase.
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_outputs("midrst", 0, 0, 0, 0, 0);
        rst_n  = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        pulse(5, 10, 1'b1);
        pulse(8, 13, 1'b1);
        pulse(1, 4, 1'b0);
        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
